dmem_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the core load/store unit (requester 0) and a secondary master such as a debug/program loader (requester 1). It sits between those masters and the data memory. It grants one access per cycle by round-robin with a bounded lock option, drives the memory port, and routes the read data back to the requester that issued the read.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory-port signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_m0_req;
  logic                  i_m0_wen;
  logic [ADDR_WIDTH-1:0] i_m0_addr;
  logic [DATA_WIDTH-1:0] i_m0_wdata;
  logic                  i_m0_lock;
  logic                  o_m0_gnt;
  logic                  o_m0_rvalid;
  logic [DATA_WIDTH-1:0] o_m0_rdata;

  logic                  i_m1_req;
  logic                  i_m1_wen;
  logic [ADDR_WIDTH-1:0] i_m1_addr;
  logic [DATA_WIDTH-1:0] i_m1_wdata;
  logic                  i_m1_lock;
  logic                  o_m1_gnt;
  logic                  o_m1_rvalid;
  logic [DATA_WIDTH-1:0] o_m1_rdata;

  logic                  o_mem_ren;
  logic                  o_mem_wen;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  // Arbiter side: consumes requests and memory read data, drives grants, responses and the memory port.
  modport slave (
    input  i_m0_req, i_m0_wen, i_m0_addr, i_m0_wdata, i_m0_lock,
    input  i_m1_req, i_m1_wen, i_m1_addr, i_m1_wdata, i_m1_lock,
    input  i_mem_rdata,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata
  );

  // Requester/memory side: the mirror image of the arbiter view.
  modport master (
    output i_m0_req, i_m0_wen, i_m0_addr, i_m0_wdata, i_m0_lock,
    output i_m1_req, i_m1_wen, i_m1_addr, i_m1_wdata, i_m1_lock,
    output i_mem_rdata,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin data-memory arbiter with bounded lock and read routing
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  dmem_arbiter_if.slave bus
);
  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  logic          last_gnt;          // index of the requester granted most recently
  logic          lock_owner_valid;
  logic          lock_owner;
  logic [CW-1:0] lock_cnt;          // consecutive grants held by the lock owner, saturating
  logic          rd_pending;
  logic          rd_owner;

  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          lock_active;
  logic          g_wen;
  logic          g_lock;

  // Grant decision: lone requester wins; on contention an unexpired lock wins, else the one not served last.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    lock_active = lock_owner_valid && (lock_cnt < LOCK_MAX);
    if (!i_rst) begin
      if (bus.i_m0_req && !bus.i_m1_req) begin
        gnt0 = 1'b1;
      end else if (bus.i_m1_req && !bus.i_m0_req) begin
        gnt1 = 1'b1;
      end else if (bus.i_m0_req && bus.i_m1_req) begin
        if (lock_active) begin
          gnt0 = ~lock_owner;
          gnt1 = lock_owner;
        end else begin
          gnt0 = last_gnt;
          gnt1 = ~last_gnt;
        end
      end
    end
  end

  assign any_gnt      = gnt0 | gnt1;
  assign g_wen        = gnt1 ? bus.i_m1_wen  : (gnt0 & bus.i_m0_wen);
  assign g_lock       = gnt1 ? bus.i_m1_lock : (gnt0 & bus.i_m0_lock);
  assign bus.o_m0_gnt = gnt0;
  assign bus.o_m1_gnt = gnt1;

  // Memory port carries the granted access only; idle cycles present an all-zero port.
  always_comb begin
    bus.o_mem_ren   = any_gnt & ~g_wen;
    bus.o_mem_wen   = any_gnt & g_wen;
    bus.o_mem_addr  = {ADDR_WIDTH{1'b0}};
    bus.o_mem_wdata = {DATA_WIDTH{1'b0}};
    if (gnt0) begin
      bus.o_mem_addr  = bus.i_m0_addr;
      bus.o_mem_wdata = bus.i_m0_wdata;
    end else if (gnt1) begin
      bus.o_mem_addr  = bus.i_m1_addr;
      bus.o_mem_wdata = bus.i_m1_wdata;
    end
  end

  // Fairness, lock tracking and read-response bookkeeping; reset discards any in-flight read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_gnt         <= 1'b1;
      lock_owner_valid <= 1'b0;
      lock_owner       <= 1'b0;
      lock_cnt         <= '0;
      rd_pending       <= 1'b0;
      rd_owner         <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_gnt <= gnt1;
      end
      if (any_gnt && g_lock) begin
        lock_owner_valid <= 1'b1;
        lock_owner       <= gnt1;
        if (lock_owner_valid && (lock_owner == gnt1)) begin
          if (lock_cnt < LOCK_MAX) begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end else begin
          lock_cnt <= CW'(1);
        end
      end else begin
        lock_owner_valid <= 1'b0;
        lock_cnt         <= '0;
      end
      rd_pending <= any_gnt & ~g_wen;
      rd_owner   <= gnt1;
    end
  end

  assign bus.o_m0_rvalid = rd_pending & ~rd_owner;
  assign bus.o_m1_rvalid = rd_pending & rd_owner;
  assign bus.o_m0_rdata  = bus.o_m0_rvalid ? bus.i_mem_rdata : {DATA_WIDTH{1'b0}};
  assign bus.o_m1_rdata  = bus.o_m1_rvalid ? bus.i_mem_rdata : {DATA_WIDTH{1'b0}};
endmodule
